pwm_ramp_ctrl: RTL

//  Duty-cycle sequencer and PWM generator for soft-start / breathing outputs (motor, LED).

---
 rtl/pwm_ramp_if.sv | 8 +
 rtl/pwm_ramp_ctrl.sv | 64 ++++++
 2 files changed

// File: rtl/pwm_ramp_if.sv
// pwm_ramp_if: valid/ready channel carrying a target duty code
interface pwm_ramp_if #(parameter int pDWIDTH = 8);
  logic               cfg_valid;
  logic [pDWIDTH-1:0] cfg_duty;
  logic               cfg_ready;
  modport master (output cfg_valid, cfg_duty, input cfg_ready);
  modport slave (input cfg_valid, cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: PWM generator whose duty ramps one code per N periods toward a handshaked target
module pwm_ramp_ctrl #(
  parameter int pWIDTH        = 20,
  parameter int pPERIOD       = 1000_000,
  parameter int pINC          = 20,
  parameter int pDWIDTH       = 8,
  parameter int pSTEP_PERIODS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  pwm_ramp_if.slave          cfg,
  output logic               wave,
  output logic               period_tick,
  output logic               busy,
  output logic [pDWIDTH-1:0] duty_cur
);
  localparam int W  = pWIDTH + pDWIDTH;
  localparam int SW = $clog2(pSTEP_PERIODS + 1);
  localparam logic [pWIDTH-1:0] LAST = pWIDTH'(pPERIOD - pINC);
  localparam logic [pWIDTH-1:0] INC  = pWIDTH'(pINC);
  localparam logic [W-1:0]      PER  = W'(pPERIOD);
  typedef enum logic [1:0] {IDLE, STEADY, RAMP} state_t;
  state_t             state, state_nxt;
  logic [pWIDTH-1:0]  cnt;
  logic [SW-1:0]      step_cnt, step_nxt;
  logic [pDWIDTH-1:0] target, tgt_nxt, duty_nxt;
  logic [W-1:0]       thr;
  logic               acc, step;
  assign period_tick = en & (cnt == LAST);
  assign thr = ({{pWIDTH{1'b0}}, duty_cur} * PER) >> pDWIDTH;
  assign acc = cfg.cfg_valid & cfg.cfg_ready;
  always_comb begin
    step     = busy & period_tick & (step_cnt == SW'(pSTEP_PERIODS - 1));
    step_nxt = (!en || !busy || step) ? '0 : step_cnt + SW'(period_tick);
    duty_nxt = !step ? duty_cur : (target > duty_cur) ? duty_cur + pDWIDTH'(1) : duty_cur - pDWIDTH'(1);
    tgt_nxt  = acc ? cfg.cfg_duty : target;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  // Every enabled state settles by comparing the post-edge target and duty
  always_comb begin
    state_nxt = !en ? IDLE : (tgt_nxt != duty_nxt) ? RAMP : STEADY;
  end
  always_comb begin
    busy          = state == RAMP;
    cfg.cfg_ready = en & ~rst & (state != RAMP);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt      <= '0;
      step_cnt <= '0;
      target   <= '0;
      duty_cur <= '0;
      wave     <= 1'b0;
    end else begin
      cnt      <= (!en || period_tick) ? '0 : cnt + INC;
      step_cnt <= step_nxt;
      target   <= tgt_nxt;
      duty_cur <= duty_nxt;
      wave     <= en & ((&duty_cur) | ({{pDWIDTH{1'b0}}, cnt} < thr));
    end
endmodule
